shift_right_register: RTL and testbench

SHIFT_RIGHT_REGISTER -- requirements
Module: shift_right_register

---
 rtl/shift_right_register.sv | 32 +++
 tb/tb_shift_right_register.sv | 139 +++++++++++++
 2 files changed

// File: rtl/shift_right_register.sv
// Serial-in, parallel-out right shift register with synchronous clear and parallel load.
// The serial input enters at the MSB, and the serial output is the current LSB.
module shift_right_register #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            i_nrst,
    input  logic            i_sclr,
    input  logic            i_load,
    input  logic [BITS-1:0] i_pdata,
    input  logic            i_en,
    input  logic            i_dat,
    output logic [BITS-1:0] o_data,
    output logic            o_sout
);

    // Control priority is clear, then load, then shift, then hold.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_data <= '0;
        end else if (i_sclr) begin
            o_data <= '0;
        end else if (i_load) begin
            o_data <= i_pdata;
        end else if (i_en) begin
            o_data <= {i_dat, o_data[BITS-1:1]};
        end
    end

    assign o_sout = o_data[0];

endmodule

// File: tb/tb_shift_right_register.sv
// Directed testbench for shift_right_register with BITS=5.
// Expected values are worked out by hand from the shift rules.
module tb_shift_right_register;

    localparam int BITS = 5;

    logic            clk;
    logic            i_nrst;
    logic            i_sclr;
    logic            i_load;
    logic [BITS-1:0] i_pdata;
    logic            i_en;
    logic            i_dat;
    logic [BITS-1:0] o_data;
    logic            o_sout;

    int checkCount;
    int failCount;

    shift_right_register #(.BITS(BITS)) dut (
        .clk    (clk),
        .i_nrst (i_nrst),
        .i_sclr (i_sclr),
        .i_load (i_load),
        .i_pdata(i_pdata),
        .i_en   (i_en),
        .i_dat  (i_dat),
        .o_data (o_data),
        .o_sout (o_sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of controls, then sample one time unit after the rising edge.
    task automatic applyStimulus(input logic sclr, input logic load, input logic en,
                                 input logic dat, input logic [BITS-1:0] pdata);
        i_sclr  = sclr;
        i_load  = load;
        i_en    = en;
        i_dat   = dat;
        i_pdata = pdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [BITS-1:0] expData,
                               input logic expSout);
        checkCount++;
        assert (o_data === expData) else begin
            failCount++;
            $error("[TB] FAIL %s data observed=%b expected=%b", tag, o_data, expData);
        end
        checkCount++;
        assert (o_sout === expSout) else begin
            failCount++;
            $error("[TB] FAIL %s sout observed=%b expected=%b", tag, o_sout, expSout);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        i_nrst  = 1'b0;
        i_sclr  = 1'b0;
        i_load  = 1'b0;
        i_en    = 1'b0;
        i_dat   = 1'b0;
        i_pdata = '0;

        #2;
        checkOutput("reset_initial", 5'b00000, 1'b0);

        // Reset held low must ignore load and shift requests.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'b11111);
        checkOutput("reset_ignores_load", 5'b00000, 1'b0);
        #2;
        i_nrst = 1'b1;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        checkOutput("sclr", 5'b00000, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000);
        checkOutput("shift1", 5'b10000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
        checkOutput("shift2", 5'b01000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000);
        checkOutput("shift3", 5'b10100, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000);
        checkOutput("shift4", 5'b11010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000);
        checkOutput("shift5", 5'b11101, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000);
        checkOutput("shift6", 5'b11110, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
        checkOutput("shift7", 5'b01111, 1'b1);

        // Hold with shift disabled while the serial input toggles.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b11111);
        checkOutput("load_ones", 5'b11111, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        checkOutput("hold1", 5'b11111, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'b00000);
        checkOutput("hold2", 5'b11111, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'bx, 5'b00000);
        checkOutput("hold3_x", 5'b11111, 1'b1);

        // Load takes priority over shift, then the serial output walks out the LSBs.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'b10110);
        checkOutput("load_over_en", 5'b10110, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
        checkOutput("sout_shift1", 5'b01011, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
        checkOutput("sout_shift2", 5'b00101, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
        checkOutput("sout_shift3", 5'b00010, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'b11111);
        checkOutput("clear_wins", 5'b00000, 1'b0);

        // Asynchronous reset in the middle of a shift sequence.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b10110);
        checkOutput("preload", 5'b10110, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000);
        checkOutput("mid_shift", 5'b11011, 1'b1);
        #3;
        i_nrst = 1'b0;
        #1;
        checkOutput("async_reset", 5'b00000, 1'b0);
        #1;
        i_nrst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000);
        checkOutput("after_reset_shift", 5'b10000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
